alu_seq_muldiv: RTL and testbench
=================================

// Module: alu_seq_muldiv
// PURPOSE
//  Parametrised, registered successor to the single-cycle datapath ALU. Adds the
//  RV32M multiply/divide ops, run on an iterative radix-2 engine. Uses a
//  valid/ready handshake on the issue side and on the result side, so the
//  execute stage can stall on multi-cycle ops. Sits in EX between operand
//  muxes and the EX/MEM register.
// PARAMETERS
//  DATA_WIDTH     32  operand/result width (>=8, power of 2)
//  OPCODE_LENGTH  5   Operation width; bit 4 selects the M-extension group
//  SHAMT_W        $clog2(DATA_WIDTH)  shift-amount bits taken from SrcB LSBs
// PORTS
//  clk        in   1               rising-edge clock
//  reset      in   1               synchronous, active-high
//  in_valid   in   1               operands + Operation valid
//  in_ready   out  1               block can accept; high only in IDLE
//  SrcA       in   DATA_WIDTH      operand A (rs1)
//  SrcB       in   DATA_WIDTH      operand B (rs2/imm)
//  Operation  in   OPCODE_LENGTH   op select, see BEHAVIOUR
//  out_valid  out  1               ALUResult valid; held until out_ready
//  out_ready  in   1               consumer takes result
//  ALUResult  out  DATA_WIDTH      registered result
//  busy       out  1               high in MUL/DIV/FIX states
// BEHAVIOUR
//  Opcodes, base group: 00 AND, 01 OR, 02 ADD, 03 XOR, 04 SUB, 05 SLT
//   (signed), 06 SLL, 07 SRL, 08 EQ, 09 SRA, 0A SGE (signed).
//  Opcodes, M group: 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU, 14 DIV, 15 DIVU,
//   16 REM, 17 REMU. Any other code -> result 0, base latency.
//  Shifts use SrcB[SHAMT_W-1:0] only. Compare ops return 1 or 0, zero-extended.
//  Reset: state=IDLE, in_ready=1, out_valid=0, busy=0, ALUResult=0; internal
//   regs cleared. Reset mid-operation aborts the op and discards its result.
//  Accept happens when in_valid & in_ready. Operands are latched at accept;
//   inputs are don't-care afterwards.
//  FSM: IDLE -> DONE     base op, unknown op, or M special case (latency 1)
//       IDLE -> MUL/DIV  M op; iterates exactly DATA_WIDTH cycles (counter
//                        DATA_WIDTH-1..0)
//       MUL/DIV -> FIX   when counter==0; FIX applies sign correction and selects
//                        hi/lo or quotient/remainder (1 cycle)
//       FIX -> DONE
//       DONE -> IDLE     on out_ready; DONE holds ALUResult stable otherwise
//  Latency, accept edge to out_valid: base = 1 cycle; M = DATA_WIDTH+2 cycles.
//  Throughput: at most one op per 2 cycles. in_ready is low in DONE even if
//   out_ready is high that cycle.
//  MUL: magnitudes multiplied unsigned (shift-add, 2*DATA_WIDTH product reg).
//   Negated in FIX if the operand signs differ. Signedness: MULH s*s,
//   MULHSU s*u, MULHU u*u. MUL returns the low half; the others the high half.
//  DIV/REM: restoring division on magnitudes. Quotient sign = sA^sB;
//   remainder sign = sA.
//  M special cases, resolved at accept, latency 1:
//   divide by 0 -> DIV/DIVU = all ones, REM/REMU = SrcA;
//   DIV of MIN by -1 -> quotient MIN, REM 0.
//  All arithmetic is modulo 2^DATA_WIDTH. No exceptions or flags.
// TESTING
//  ADD 0x7FFFFFFF+1, out_ready=1 -> out_valid 1 cycle after accept,
//   result 0x80000000; in_ready back high the next cycle.
//  MULH 0xFFFFFFFF(-1) * 0x00000002 -> 0xFFFFFFFF after exactly 34 cycles;
//   MULHU with the same operands -> 0x00000001; MUL -> 0xFFFFFFFE.
//  DIV -7 / 2 -> 0xFFFFFFFD (-3); REM -7 % 2 -> 0xFFFFFFFF (-1);
//   DIVU 0x80000000 / 0 -> 0xFFFFFFFF at latency 1.
//  DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
//  Backpressure: out_ready=0 for 5 cycles after SLT(-1,1) completes ->
//   out_valid and ALUResult=1 held stable, in_ready=0; drops 1 cycle after
//   out_ready.
//  Assert reset at cycle 10 of a DIVU -> next cycle in_ready=1, out_valid=0,
//   busy=0, ALUResult=0; a following AND 0xF0F0&0xFF00 -> 0xF000.

Source files
------------

// File: rtl/alu_seq_muldiv.sv
// Registered EX-stage ALU with valid/ready handshakes on issue and result.
// RV32M multiply/divide run on an iterative radix-2 shift-add / restoring engine.
module alu_seq_muldiv #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 5,
    parameter int SHAMT_W       = $clog2(DATA_WIDTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    ALUResult,
    output logic                     busy
);
    // state | meaning
    // IDLE  | waiting for an op, in_ready high
    // MUL   | shift-add iteration, one multiplier bit per cycle
    // DIV   | restoring division, one quotient bit per cycle
    // FIX   | sign correction and hi/lo or quotient/remainder select
    // DONE  | result presented, held until out_ready

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

    localparam logic [OPCODE_LENGTH-1:0] OP_AND = OPCODE_LENGTH'(0);
    localparam logic [OPCODE_LENGTH-1:0] OP_OR  = OPCODE_LENGTH'(1);
    localparam logic [OPCODE_LENGTH-1:0] OP_ADD = OPCODE_LENGTH'(2);
    localparam logic [OPCODE_LENGTH-1:0] OP_XOR = OPCODE_LENGTH'(3);
    localparam logic [OPCODE_LENGTH-1:0] OP_SUB = OPCODE_LENGTH'(4);
    localparam logic [OPCODE_LENGTH-1:0] OP_SLT = OPCODE_LENGTH'(5);
    localparam logic [OPCODE_LENGTH-1:0] OP_SLL = OPCODE_LENGTH'(6);
    localparam logic [OPCODE_LENGTH-1:0] OP_SRL = OPCODE_LENGTH'(7);
    localparam logic [OPCODE_LENGTH-1:0] OP_EQ  = OPCODE_LENGTH'(8);
    localparam logic [OPCODE_LENGTH-1:0] OP_SRA = OPCODE_LENGTH'(9);
    localparam logic [OPCODE_LENGTH-1:0] OP_SGE = OPCODE_LENGTH'(10);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  acc;
    logic [W-1:0]  lo;
    logic [W-1:0]  mag_b;
    logic [2:0]    op_r;
    logic          neg_res;
    logic          neg_rem;

    logic [2:0]         m_op;
    logic               is_m;
    logic               is_divop;
    logic               a_signed;
    logic               b_signed;
    logic               sign_a;
    logic               sign_b;
    logic               special;
    logic [W-1:0]       mag_a_c;
    logic [W-1:0]       mag_b_c;
    logic [W-1:0]       spec_res;
    logic [W-1:0]       base_res;
    logic [SHAMT_W-1:0] shamt;

    always_comb begin
        m_op     = Operation[2:0];
        is_m     = (Operation[OPCODE_LENGTH-1:3] == (OPCODE_LENGTH-3)'(2));
        is_divop = m_op[2];
        a_signed = (m_op == 3'd1) || (m_op == 3'd2) || (m_op == 3'd4) || (m_op == 3'd6);
        b_signed = (m_op == 3'd1) || (m_op == 3'd4) || (m_op == 3'd6);
        sign_a   = a_signed & SrcA[W-1];
        sign_b   = b_signed & SrcB[W-1];
        mag_a_c  = sign_a ? -SrcA : SrcA;
        mag_b_c  = sign_b ? -SrcB : SrcB;
        special  = 1'b0;
        spec_res = '0;
        // Division corner cases bypass the engine and finish like a base op
        if (is_divop && (SrcB == '0)) begin
            special  = 1'b1;
            spec_res = m_op[1] ? SrcA : '1;
        end else if (is_divop && !m_op[0] && (SrcA == MIN_VAL) && (SrcB == '1)) begin
            special  = 1'b1;
            spec_res = m_op[1] ? '0 : MIN_VAL;
        end
    end

    always_comb begin
        shamt    = SrcB[SHAMT_W-1:0];
        base_res = '0;
        case (Operation)
            OP_AND: base_res = SrcA & SrcB;
            OP_OR:  base_res = SrcA | SrcB;
            OP_ADD: base_res = SrcA + SrcB;
            OP_XOR: base_res = SrcA ^ SrcB;
            OP_SUB: base_res = SrcA - SrcB;
            OP_SLT: base_res = {{(W-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            OP_SLL: base_res = SrcA << shamt;
            OP_SRL: base_res = SrcA >> shamt;
            OP_EQ:  base_res = {{(W-1){1'b0}}, (SrcA == SrcB)};
            OP_SRA: base_res = $signed(SrcA) >>> shamt;
            OP_SGE: base_res = {{(W-1){1'b0}}, ($signed(SrcA) >= $signed(SrcB))};
            default: base_res = '0;
        endcase
    end

    logic [W:0] mul_sum;
    logic [W:0] div_shift;
    logic [W:0] div_trial;

    always_comb begin
        mul_sum   = {1'b0, acc} + {1'b0, (lo[0] ? mag_b : '0)};
        div_shift = {acc, lo[W-1]};
        div_trial = div_shift - {1'b0, mag_b};
    end

    logic [2*W-1:0] prod;
    logic [W-1:0]   quot;
    logic [W-1:0]   rem;
    logic [W-1:0]   fix_res;

    always_comb begin
        prod = {acc, lo};
        if (neg_res) prod = -prod;
        quot = neg_res ? -lo : lo;
        rem  = neg_rem ? -acc : acc;
        if (op_r[2])
            fix_res = op_r[1] ? rem : quot;
        else
            fix_res = (op_r == 3'd0) ? prod[W-1:0] : prod[2*W-1:W];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            ALUResult <= '0;
            cnt       <= '0;
            acc       <= '0;
            lo        <= '0;
            mag_b     <= '0;
            op_r      <= '0;
            neg_res   <= 1'b0;
            neg_rem   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        if (is_m && !special) begin
                            acc     <= '0;
                            lo      <= mag_a_c;
                            mag_b   <= mag_b_c;
                            op_r    <= m_op;
                            neg_res <= sign_a ^ sign_b;
                            neg_rem <= sign_a;
                            cnt     <= CW'(W-1);
                            busy    <= 1'b1;
                            state   <= is_divop ? S_DIV : S_MUL;
                        end else begin
                            ALUResult <= is_m ? spec_res : base_res;
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    acc <= mul_sum[W:1];
                    lo  <= {mul_sum[0], lo[W-1:1]};
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) state <= S_FIX;
                end
                S_DIV: begin
                    if (!div_trial[W]) begin
                        acc <= div_trial[W-1:0];
                        lo  <= {lo[W-2:0], 1'b1};
                    end else begin
                        acc <= div_shift[W-1:0];
                        lo  <= {lo[W-2:0], 1'b0};
                    end
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) state <= S_FIX;
                end
                S_FIX: begin
                    ALUResult <= fix_res;
                    busy      <= 1'b0;
                    out_valid <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Scoreboard bench for alu_seq_muldiv: driver pushes model results, monitor pops on handshake.
module tb_alu_seq_muldiv;
    localparam int W = 32;
    localparam logic [31:0] MINV = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] SrcA = '0;
    logic [31:0] SrcB = '0;
    logic [4:0]  Operation = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] ALUResult;
    logic        busy;

    alu_seq_muldiv #(.DATA_WIDTH(W), .OPCODE_LENGTH(5)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
        .out_valid(out_valid), .out_ready(out_ready), .ALUResult(ALUResult), .busy(busy)
    );

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   head_seen = 0;
    bit   force_lo = 0;
    bit   rand_rdy = 0;

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end
    initial forever begin
        @(posedge clk); #2;
        if (force_lo) out_ready = 1'b0;
        else out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference semantics from plain wide arithmetic
    function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic signed [63:0] p;
        logic [63:0] pu;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            5'h00: return a & b;
            5'h01: return a | b;
            5'h02: return a + b;
            5'h03: return a ^ b;
            5'h04: return a - b;
            5'h05: return (sa < sb) ? 32'd1 : 32'd0;
            5'h06: return a << b[4:0];
            5'h07: return a >> b[4:0];
            5'h08: return (a == b) ? 32'd1 : 32'd0;
            5'h09: return 32'($signed(a) >>> b[4:0]);
            5'h0A: return (sa >= sb) ? 32'd1 : 32'd0;
            5'h10: begin p = sa * sb; return p[31:0]; end
            5'h11: begin p = sa * sb; return p[63:32]; end
            5'h12: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
            5'h13: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
            5'h14: return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
            5'h15: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            5'h16: return (b == 0) ? a : 32'(sa % sb);
            5'h17: return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int exp_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op < 5'h10 || op > 5'h17) return 1;
        if (op >= 5'h14 && b == 0) return 1;
        if ((op == 5'h14 || op == 5'h16) && a == MINV && b == 32'hFFFF_FFFF) return 1;
        return W + 2;
    endfunction

    // Called at posedge+1; returns at posedge+1 right after the accepting edge
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int guard;
        in_valid = 1'b1; Operation = op; SrcA = a; SrcB = b;
        guard = 0;
        while (in_ready !== 1'b1) begin
            @(posedge clk); #1;
            guard++;
            if (guard > 200) begin
                tests++; fails++;
                $display("FAIL issue_timeout: in_ready stuck at %b, required 1", in_ready);
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
        e.res = model(op, a, b);
        e.lat = exp_lat(op, a, b);
        e.acc = cyc;
        sbq.push_back(e);
        in_valid = 1'b0;
        SrcA = $urandom; SrcB = $urandom; Operation = 5'($urandom);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sbq.size() != 0) begin
            @(posedge clk); #1;
            guard++;
            if (guard > 1000) begin
                tests++; fails++;
                $display("FAIL drain_timeout: %0d results outstanding, required 0", sbq.size());
                sbq.delete();
                head_seen = 0;
            end
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return MINV;
            3: return 32'd1;
            4: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    // Monitor
    initial forever begin
        @(negedge clk);
        if (!reset && out_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_result: out_valid=1 result %h with nothing outstanding", ALUResult);
            end else begin
                if (!head_seen) begin
                    check("latency", 32'(cyc - sbq[0].acc + 1), 32'(sbq[0].lat));
                    head_seen = 1;
                end
                check("result", ALUResult, sbq[0].res);
                check("in_ready_in_done", {31'b0, in_ready}, 32'd0);
                if (out_ready) begin
                    void'(sbq.pop_front());
                    head_seen = 0;
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_result", ALUResult, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        issue(5'h02, 32'h7FFF_FFFF, 32'd1);
        check("add_in_ready_low", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1;
        check("add_in_ready_back", {31'b0, in_ready}, 32'd1);

        issue(5'h11, 32'hFFFF_FFFF, 32'd2);
        issue(5'h13, 32'hFFFF_FFFF, 32'd2);
        issue(5'h10, 32'hFFFF_FFFF, 32'd2);
        issue(5'h14, 32'hFFFF_FFF9, 32'd2);
        issue(5'h16, 32'hFFFF_FFF9, 32'd2);
        issue(5'h15, MINV, 32'd0);
        issue(5'h14, MINV, 32'hFFFF_FFFF);
        issue(5'h16, MINV, 32'hFFFF_FFFF);
        issue(5'h12, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drain();

        // Backpressure on a completed SLT
        force_lo = 1; out_ready = 1'b0;
        issue(5'h05, 32'hFFFF_FFFF, 32'd1);
        repeat (5) begin
            @(posedge clk); #1;
            check("bp_out_valid", {31'b0, out_valid}, 32'd1);
            check("bp_result", ALUResult, 32'd1);
            check("bp_in_ready", {31'b0, in_ready}, 32'd0);
        end
        force_lo = 0; out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", {31'b0, out_valid}, 32'd0);
        check("bp_release_ready", {31'b0, in_ready}, 32'd1);
        drain();

        // Reset in the middle of a DIVU
        issue(5'h15, 32'h1234_5678, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        check("mid_busy", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sbq.delete();
        head_seen = 0;
        check("abort_in_ready", {31'b0, in_ready}, 32'd1);
        check("abort_out_valid", {31'b0, out_valid}, 32'd0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_result", ALUResult, 32'd0);
        issue(5'h00, 32'h0000_F0F0, 32'h0000_FF00);
        drain();

        rand_rdy = 1;
        repeat (150) issue(5'($urandom_range(0, 31)), pick(), pick());
        drain();
        rand_rdy = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end
endmodule
